voxel_stream_unpacker: RTL and testbench
========================================

Name: voxel_stream_unpacker

Overview:
Sits directly upstream of the scene loader interface and feeds its load_mode/load_valid/load_ready/load_addr/load_data port. Accepts the scene as a packed byte stream (8 voxels per byte) over a valid/ready handshake and expands it into one voxel-bit write request per cycle with auto-incrementing addresses. Sequences a full scene load from start to done, including load_mode control, so the host side never generates voxel addresses.

Parameters:
ADDR_BITS, 15, voxel address width; scene depth = 2**ADDR_BITS voxels, byte count = 2**ADDR_BITS/8 (ADDR_BITS >= 3)
LSB_FIRST, 1, 1: byte bit 0 maps to the lowest address of its group of 8; 0: bit 7 maps to the lowest address

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  single-cycle pulse, begins a scene load (honoured in IDLE and DONE only)
abort  input  1  single-cycle pulse, cancels a load in progress
in_valid  input  1  byte stream valid
in_ready  output  1  byte stream ready
in_data  input  8  packed voxel byte
load_mode  output  1  to loader, high for the whole load
load_valid  output  1  to loader, voxel request valid
load_ready  input  1  from loader, request accepted
load_addr  output  ADDR_BITS  voxel address
load_data  output  1  voxel occupancy bit
busy  output  1  high in LOAD
done  output  1  high in DONE (sticky)

Behaviour:
- Reset (async, any time): state=IDLE; every output 0; address counter, byte counter, bit index, buffer-full flag cleared. Reset mid-load abandons the load with no further requests.
- States: IDLE, LOAD, DONE.
- IDLE: load_mode=0, in_ready=0, load_valid=0. start -> LOAD, address=0, byte count=0, buffer empty.
- LOAD: load_mode=1, busy=1.
  - Byte buffer: one 8-bit register + 3-bit bit index + full flag.
  - in_ready = buffer empty OR (load_valid AND load_ready AND bit index=7), AND fewer than DEPTH/8 bytes accepted. Byte accepted on in_valid AND in_ready.
  - Acceptance loads the buffer, sets bit index=0, sets full. load_valid is registered: first request of that byte appears the cycle after acceptance.
  - load_valid = buffer full. load_data = buffer bit selected by bit index (LSB_FIRST=1: bit index; else 7-bit index). load_addr = address counter.
  - On load_valid AND load_ready: address+1, bit index+1. At bit index 7 the buffer empties unless a new byte is accepted in the same cycle (back-to-back, zero bubble): sustained throughput 1 voxel/cycle.
  - Stall: while load_valid AND NOT load_ready, load_valid/load_addr/load_data held stable.
  - Transfer of address DEPTH-1 -> DONE on the next edge; the address counter never wraps, no request beyond DEPTH-1.
  - abort -> IDLE next edge, buffer discarded, outputs as IDLE. abort takes priority over any same-cycle transfer/acceptance state update; a transfer in flight that cycle is still seen by the loader.
  - start in LOAD ignored.
- DONE: done=1, load_mode=0, load_valid=0, in_ready=0. start -> LOAD (fresh load, done cleared same edge). abort in DONE -> IDLE.
- start and abort in same cycle: abort wins.
- Byte count width ADDR_BITS-2 bits; address counter ADDR_BITS bits.

Test Plan:
- Reset: assert rst mid-LOAD at address 1000 -> all outputs 0 immediately (async), state IDLE; no load_valid until next start.
- Full load, in_valid=1 and load_ready=1 continuously, ADDR_BITS=15: exactly 32768 transfers, addresses 0..32767 in order, 4096 bytes accepted, done=1 and load_mode=0 one cycle after last transfer, total ~32770 cycles from start.
- Bit ordering: first byte 0xA5, LSB_FIRST=1 -> addr0..7 data 1,0,1,0,0,1,0,1; LSB_FIRST=0 -> 1,0,1,0,0,1,0,1 reversed per bit (bit7 first) i.e. 1,0,1,0,0,1,0,1 for 0xA5 palindrome; repeat with 0x01 -> LSB_FIRST=1 addr0=1, LSB_FIRST=0 addr7=1.
- Backpressure: load_ready random 50% and in_valid random gaps -> load_addr/load_data stable while stalled, no skipped or duplicated addresses, in_ready never high while buffer full and not draining bit 7.
- abort at address 12345 -> IDLE next cycle, load_mode=0, done=0; subsequent start reloads from address 0.
- start pulsed during LOAD -> ignored (address sequence unbroken); start in DONE -> done falls, new load from address 0.

Source files
------------

// File: rtl/voxel_stream_unpacker.sv
// Expands a packed voxel byte stream (8 voxels per byte) into one voxel-bit load request
// per cycle with auto-incrementing addresses, sequencing a whole scene load start to done.
module voxel_stream_unpacker #(
    parameter int unsigned ADDR_BITS = 15,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    output logic                 load_mode,
    output logic                 load_valid,
    input  logic                 load_ready,
    output logic [ADDR_BITS-1:0] load_addr,
    output logic                 load_data,
    output logic                 busy,
    output logic                 done
);

    localparam logic [ADDR_BITS-1:0] LastAddr = {ADDR_BITS{1'b1}};
    localparam logic [ADDR_BITS-2:0] NumBytes = (ADDR_BITS - 1)'(2 ** (ADDR_BITS - 3));

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e               state;
    logic [ADDR_BITS-1:0] addr;
    logic [ADDR_BITS-2:0] byte_cnt;
    logic [2:0]           bit_idx;
    logic                 full;
    logic [7:0]           byte_buf;
    logic                 xfer;
    logic                 last_bit;
    logic                 accept;
    logic [2:0]           sel;

    assign xfer     = full & load_ready;
    assign last_bit = (bit_idx == 3'd7);
    // A new byte may land in the same cycle the last bit of the current one drains.
    assign in_ready = (state == StLoad) && (!full || (xfer && last_bit)) &&
                      (byte_cnt < NumBytes);
    assign accept   = in_valid & in_ready;

    assign sel        = LSB_FIRST ? bit_idx : ~bit_idx;
    assign load_valid = full;
    assign load_addr  = addr;
    assign load_data  = full & byte_buf[sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            addr      <= '0;
            byte_cnt  <= '0;
            bit_idx   <= '0;
            full      <= 1'b0;
            byte_buf  <= '0;
            load_mode <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start && !abort) begin
                        state     <= StLoad;
                        addr      <= '0;
                        byte_cnt  <= '0;
                        bit_idx   <= '0;
                        full      <= 1'b0;
                        load_mode <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                StLoad: begin
                    if (abort) begin
                        state     <= StIdle;
                        addr      <= '0;
                        full      <= 1'b0;
                        load_mode <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        if (xfer) begin
                            bit_idx <= bit_idx + 3'd1;
                            if (last_bit) full <= 1'b0;
                            // Last voxel: hold the counter rather than wrap.
                            if (addr == LastAddr) begin
                                state     <= StDone;
                                load_mode <= 1'b0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                            end else begin
                                addr <= addr + 1'b1;
                            end
                        end
                        if (accept) begin
                            byte_buf <= in_data;
                            bit_idx  <= '0;
                            full     <= 1'b1;
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (abort) begin
                        state <= StIdle;
                        done  <= 1'b0;
                    end else if (start) begin
                        state     <= StLoad;
                        done      <= 1'b0;
                        addr      <= '0;
                        byte_cnt  <= '0;
                        bit_idx   <= '0;
                        full      <= 1'b0;
                        load_mode <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_voxel_stream_unpacker.sv
// Randomized bench for voxel_stream_unpacker: a 15-bit LSB-first instance and a small
// 6-bit MSB-first instance share the byte stream and loader ready.
module tb_voxel_stream_unpacker;

    localparam int DEPTH_A = 32768;
    localparam int DEPTH_B = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       load_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;

    logic        a_in_ready, a_load_mode, a_load_valid, a_load_data, a_busy, a_done;
    logic [14:0] a_load_addr;
    logic        b_in_ready, b_load_mode, b_load_valid, b_load_data, b_busy, b_done;
    logic [5:0]  b_load_addr;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       valid;
        logic       ready;
        logic       in_rdy;
        logic       data;
        logic [5:0] addr;
    } snap_t;

    logic [7:0] a_bytes[$];
    logic [7:0] b_bytes[$];
    int         a_addrs[$];
    int         b_addrs[$];
    bit         a_data[$];
    bit         b_data[$];
    snap_t      b_log[$];

    voxel_stream_unpacker #(.ADDR_BITS(15), .LSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .load_mode(a_load_mode), .load_valid(a_load_valid), .load_ready(load_ready),
        .load_addr(a_load_addr), .load_data(a_load_data), .busy(a_busy), .done(a_done)
    );

    voxel_stream_unpacker #(.ADDR_BITS(6), .LSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .load_mode(b_load_mode), .load_valid(b_load_valid), .load_ready(load_ready),
        .load_addr(b_load_addr), .load_data(b_load_data), .busy(b_busy), .done(b_done)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Voxel value of position pos within its source byte.
    function automatic bit voxel_of(input logic [7:0] b, input int pos, input bit lsb);
        return lsb ? b[pos] : b[7 - pos];
    endfunction

    // Records handshakes seen before the coming edge, then advances one cycle.
    task automatic tick();
        snap_t s;
        #1;
        if (a_in_ready && in_valid) a_bytes.push_back(in_data);
        if (b_in_ready && in_valid) b_bytes.push_back(in_data);
        if (a_load_valid && load_ready) begin
            a_addrs.push_back(int'(a_load_addr));
            a_data.push_back(a_load_data);
        end
        if (b_load_valid && load_ready) begin
            b_addrs.push_back(int'(b_load_addr));
            b_data.push_back(b_load_data);
        end
        s.valid  = b_load_valid;
        s.ready  = load_ready;
        s.in_rdy = b_in_ready;
        s.data   = b_load_data;
        s.addr   = b_load_addr;
        b_log.push_back(s);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        a_bytes.delete(); b_bytes.delete();
        a_addrs.delete(); b_addrs.delete();
        a_data.delete();  b_data.delete();
        b_log.delete();
    endtask

    task automatic test_reset();
        int  n;
        bit  seen_valid;
        n_cmp++;
        if ({a_in_ready, a_load_mode, a_load_valid, a_load_data, a_busy, a_done, a_load_addr}
            !== '0) begin
            n_fail++;
            $display("FAIL reset_a_outputs: got %h, want 0", {a_in_ready, a_load_mode,
                     a_load_valid, a_load_data, a_busy, a_done, a_load_addr});
        end
        n_cmp++;
        if ({b_in_ready, b_load_mode, b_load_valid, b_load_data, b_busy, b_done, b_load_addr}
            !== '0) begin
            n_fail++;
            $display("FAIL reset_b_outputs: got %h, want 0", {b_in_ready, b_load_mode,
                     b_load_valid, b_load_data, b_busy, b_done, b_load_addr});
        end
        rst = 1'b0;
        tick();
        clear_logs();
        in_valid = 1'b1;
        load_ready = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int c = 0; c < 1100 && a_addrs.size() < 1000; c++) begin
            in_data = 8'($urandom);
            tick();
        end
        n_cmp++;
        if (a_load_addr !== 15'd1000 || a_load_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_reach_1000: got addr %0d valid %b, want 1000 valid 1",
                     a_load_addr, a_load_valid);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({a_in_ready, a_load_mode, a_load_valid, a_load_data, a_busy, a_done, a_load_addr}
            !== '0) begin
            n_fail++;
            $display("FAIL reset_async_clear: got %h, want 0", {a_in_ready, a_load_mode,
                     a_load_valid, a_load_data, a_busy, a_done, a_load_addr});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        n = a_addrs.size();
        seen_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (a_load_valid) seen_valid = 1'b1;
        end
        n_cmp++;
        if (a_addrs.size() !== n || seen_valid !== 1'b0 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_requests: got %0d new xfers valid_seen %b busy %b, want 0 0 0",
                     a_addrs.size() - n, seen_valid, a_busy);
        end
    endtask

    task automatic test_full_load();
        int cycles;
        int last_xfer;
        int bad_addr;
        int bad_data;
        int n;
        clear_logs();
        in_valid = 1'b1;
        load_ready = 1'b1;
        start_a = 1'b1;
        in_data = 8'($urandom);
        tick();
        start_a = 1'b0;
        cycles = 1;
        last_xfer = -1;
        while (!a_done && cycles < 33000) begin
            in_data = 8'($urandom);
            tick();
            cycles++;
            if (last_xfer < 0 && a_addrs.size() == DEPTH_A) last_xfer = cycles;
        end
        n_cmp++;
        if (a_done !== 1'b1 || cycles !== 32770) begin
            n_fail++;
            $display("FAIL full_cycles: got done %b after %0d cycles, want done 1 after 32770",
                     a_done, cycles);
        end
        n_cmp++;
        if (a_addrs.size() !== DEPTH_A || a_bytes.size() !== DEPTH_A / 8) begin
            n_fail++;
            $display("FAIL full_counts: got %0d xfers %0d bytes, want 32768 4096",
                     a_addrs.size(), a_bytes.size());
        end
        bad_addr = 0;
        bad_data = 0;
        foreach (a_addrs[i]) begin
            if (a_addrs[i] != i) bad_addr++;
            if (i / 8 >= a_bytes.size()) bad_data++;
            else if (a_data[i] != voxel_of(a_bytes[i / 8], i % 8, 1'b1)) bad_data++;
        end
        n_cmp++;
        if (bad_addr !== 0) begin
            n_fail++;
            $display("FAIL full_addr_order: got %0d out-of-order addresses, want 0", bad_addr);
        end
        n_cmp++;
        if (bad_data !== 0) begin
            n_fail++;
            $display("FAIL full_data: got %0d wrong voxel bits, want 0", bad_data);
        end
        n_cmp++;
        if (last_xfer !== cycles || a_load_mode !== 1'b0 || a_load_valid !== 1'b0 ||
            a_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_done_timing: got last_xfer %0d done_cycle %0d mode %b valid %b rdy %b, want equal cycles 0 0 0",
                     last_xfer, cycles, a_load_mode, a_load_valid, a_in_ready);
        end
        n = a_addrs.size();
        for (int c = 0; c < 5; c++) tick();
        n_cmp++;
        if (a_addrs.size() !== n || a_done !== 1'b1) begin
            n_fail++;
            $display("FAIL full_done_sticky: got %0d extra xfers done %b, want 0 1",
                     a_addrs.size() - n, a_done);
        end
    endtask

    task automatic test_bit_order();
        logic [7:0] pat0, pat1, rev0, rev1, av0, av1, bv0, bv1;
        int bad;
        pat0 = 8'hA5;
        pat1 = 8'h01;
        for (int k = 0; k < 8; k++) begin
            rev0[k] = pat0[7 - k];
            rev1[k] = pat1[7 - k];
        end
        clear_logs();
        in_valid = 1'b1;
        load_ready = 1'b1;
        in_data = pat0;
        start_a = 1'b1;
        start_b = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        n_cmp++;
        if (a_done !== 1'b0 || a_busy !== 1'b1 || b_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_from_done: got done %b busy_a %b busy_b %b, want 0 1 1",
                     a_done, a_busy, b_busy);
        end
        for (int c = 0; c < 24; c++) begin
            if (a_bytes.size() == 0) in_data = pat0;
            else if (a_bytes.size() == 1) in_data = pat1;
            else in_data = 8'($urandom);
            tick();
        end
        abort_a = 1'b1;
        abort_b = 1'b1;
        tick();
        abort_a = 1'b0;
        abort_b = 1'b0;
        av0 = '0; av1 = '0; bv0 = '0; bv1 = '0;
        bad = 0;
        if (a_data.size() < 16 || b_data.size() < 16) bad = 99;
        else begin
            for (int k = 0; k < 8; k++) begin
                av0[k] = a_data[k];
                av1[k] = a_data[8 + k];
                bv0[k] = b_data[k];
                bv1[k] = b_data[8 + k];
            end
            for (int k = 0; k < 16; k++) begin
                if (a_addrs[k] != k) bad++;
                if (b_addrs[k] != k) bad++;
            end
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL order_addrs: got %0d bad/missing addresses, want 0", bad);
        end
        n_cmp++;
        if (av0 !== pat0 || av1 !== pat1) begin
            n_fail++;
            $display("FAIL order_lsb_first: got %h %h, want %h %h", av0, av1, pat0, pat1);
        end
        n_cmp++;
        if (bv0 !== rev0 || bv1 !== rev1) begin
            n_fail++;
            $display("FAIL order_msb_first: got %h %h, want %h %h", bv0, bv1, rev0, rev1);
        end
        n_cmp++;
        if (a_load_mode !== 1'b0 || a_done !== 1'b0 || b_load_mode !== 1'b0 ||
            b_load_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL order_abort: got mode_a %b done_a %b mode_b %b valid_b %b, want 0 0 0 0",
                     a_load_mode, a_done, b_load_mode, b_load_valid);
        end
    endtask

    task automatic test_backpressure();
        int c;
        int bad_addr, bad_data, bad_hold, bad_rdy, stalls;
        clear_logs();
        in_valid = 1'b0;
        load_ready = 1'b0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        c = 0;
        while (!b_done && c < 3000) begin
            load_ready = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 9) < 6);
            in_data = 8'($urandom);
            tick();
            c++;
        end
        n_cmp++;
        if (b_done !== 1'b1 || b_addrs.size() !== DEPTH_B || b_bytes.size() !== DEPTH_B / 8) begin
            n_fail++;
            $display("FAIL bp_counts: got done %b %0d xfers %0d bytes, want 1 64 8",
                     b_done, b_addrs.size(), b_bytes.size());
        end
        bad_addr = 0;
        bad_data = 0;
        foreach (b_addrs[i]) begin
            if (b_addrs[i] != i) bad_addr++;
            if (i / 8 >= b_bytes.size()) bad_data++;
            else if (b_data[i] != voxel_of(b_bytes[i / 8], i % 8, 1'b0)) bad_data++;
        end
        n_cmp++;
        if (bad_addr !== 0 || bad_data !== 0) begin
            n_fail++;
            $display("FAIL bp_sequence: got %0d bad addrs %0d bad bits, want 0 0",
                     bad_addr, bad_data);
        end
        bad_hold = 0;
        bad_rdy = 0;
        stalls = 0;
        for (int i = 0; i + 1 < b_log.size(); i++) begin
            if (b_log[i].valid && !b_log[i].ready) begin
                stalls++;
                if (!b_log[i + 1].valid || b_log[i + 1].addr != b_log[i].addr ||
                    b_log[i + 1].data != b_log[i].data) bad_hold++;
            end
            if (b_log[i].in_rdy && b_log[i].valid &&
                !(b_log[i].ready && b_log[i].addr[2:0] == 3'd7)) bad_rdy++;
        end
        n_cmp++;
        if (bad_hold !== 0 || stalls == 0) begin
            n_fail++;
            $display("FAIL bp_stall_stable: got %0d unstable of %0d stalls, want 0 of >0",
                     bad_hold, stalls);
        end
        n_cmp++;
        if (bad_rdy !== 0) begin
            n_fail++;
            $display("FAIL bp_in_ready_rule: got %0d illegal in_ready cycles, want 0", bad_rdy);
        end
    endtask

    task automatic test_start_during_load();
        int c;
        int bad;
        clear_logs();
        in_valid = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        c = 0;
        while (!b_done && c < 600) begin
            load_ready = ($urandom_range(0, 3) != 0);
            in_data = 8'($urandom);
            start_b = (c == 15 || c == 40);
            tick();
            c++;
        end
        start_b = 1'b0;
        bad = 0;
        foreach (b_addrs[i]) if (b_addrs[i] != i) bad++;
        n_cmp++;
        if (b_done !== 1'b1 || b_addrs.size() !== DEPTH_B || bad !== 0) begin
            n_fail++;
            $display("FAIL start_in_load_ignored: got done %b %0d xfers %0d bad, want 1 64 0",
                     b_done, b_addrs.size(), bad);
        end
        clear_logs();
        load_ready = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n_cmp++;
        if (b_done !== 1'b0 || b_busy !== 1'b1 || b_load_mode !== 1'b1) begin
            n_fail++;
            $display("FAIL start_in_done: got done %b busy %b mode %b, want 0 1 1",
                     b_done, b_busy, b_load_mode);
        end
        c = 0;
        while (!b_done && c < 200) begin
            in_data = 8'($urandom);
            tick();
            c++;
        end
        bad = 0;
        foreach (b_addrs[i]) begin
            if (b_addrs[i] != i) bad++;
            else if (b_data[i] != voxel_of(b_bytes[i / 8], i % 8, 1'b0)) bad++;
        end
        n_cmp++;
        if (b_addrs.size() !== DEPTH_B || bad !== 0) begin
            n_fail++;
            $display("FAIL reload_b: got %0d xfers %0d bad, want 64 0", b_addrs.size(), bad);
        end
    endtask

    task automatic test_abort();
        int n;
        int bad;
        clear_logs();
        in_valid = 1'b1;
        load_ready = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int c = 0; c < 12500 && a_addrs.size() < 12345; c++) begin
            in_data = 8'($urandom);
            tick();
        end
        n_cmp++;
        if (a_load_addr !== 15'd12345 || a_load_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_reach_12345: got addr %0d valid %b, want 12345 1",
                     a_load_addr, a_load_valid);
        end
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        n_cmp++;
        if (a_addrs.size() !== 12346) begin
            n_fail++;
            $display("FAIL abort_inflight_seen: got %0d xfers, want 12346", a_addrs.size());
        end
        n_cmp++;
        if (a_load_mode !== 1'b0 || a_done !== 1'b0 || a_busy !== 1'b0 ||
            a_load_valid !== 1'b0 || a_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got mode %b done %b busy %b valid %b rdy %b, want all 0",
                     a_load_mode, a_done, a_busy, a_load_valid, a_in_ready);
        end
        n = a_addrs.size();
        start_a = 1'b1;
        abort_a = 1'b1;
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        n_cmp++;
        if (a_busy !== 1'b0 || a_addrs.size() !== n) begin
            n_fail++;
            $display("FAIL abort_beats_start: got busy %b %0d new xfers, want 0 0",
                     a_busy, a_addrs.size() - n);
        end
        clear_logs();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int c = 0; c < 40; c++) begin
            in_data = 8'($urandom);
            tick();
        end
        bad = 0;
        foreach (a_addrs[i]) begin
            if (a_addrs[i] != i) bad++;
            else if (a_data[i] != voxel_of(a_bytes[i / 8], i % 8, 1'b1)) bad++;
        end
        n_cmp++;
        if (a_addrs.size() < 30 || bad !== 0) begin
            n_fail++;
            $display("FAIL abort_reload: got %0d xfers %0d bad, want >=30 0", a_addrs.size(), bad);
        end
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_full_load();
        test_bit_order();
        test_backpressure();
        test_start_during_load();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
